// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold, direct handoff on release and optional
// hold-limit preemption. gnt, gnt_valid and gnt_idx are registered.
module rr_hold_arbiter #(
    parameter int N        = 5,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             state_dbg
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    // hold_cnt stops here; with a hold limit this is also the preemption point.
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              req_own;
    logic [N-1:0]      others;
    logic [IDX_W:0]    pick_all;
    logic [IDX_W:0]    pick_oth;
    logic              take;
    logic              go_idle;
    logic [IDX_W-1:0]  win;

    // Returns {found, index} of the first candidate scanning from start upward with wrap.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] cand,
                                            input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (cand[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign req_own   = req[gnt_idx];
    assign others    = req & ~gnt;
    assign pick_all  = pick(req, ptr);
    assign pick_oth  = pick(others, ptr);
    assign state_dbg = (state == GRANT);

    always_comb begin
        take    = 1'b0;
        go_idle = 1'b0;
        win     = '0;
        case (state)
            IDLE: begin
                if (pick_all[IDX_W]) begin
                    take = 1'b1;
                    win  = pick_all[IDX_W-1:0];
                end
            end
            GRANT: begin
                if (!req_own) begin
                    if (pick_oth[IDX_W]) begin
                        take = 1'b1;
                        win  = pick_oth[IDX_W-1:0];
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_SAT && pick_oth[IDX_W]) begin
                    take = 1'b1;
                    win  = pick_oth[IDX_W-1:0];
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (take) begin
            state     <= GRANT;
            gnt       <= N'(1) << win;
            gnt_valid <= 1'b1;
            gnt_idx   <= win;
            ptr       <= (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
            hold_cnt  <= '0;
        end else if (go_idle) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
        end else if (state == GRANT && hold_cnt != HOLD_SAT) begin
            hold_cnt  <= hold_cnt + HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: one instance without a hold limit and one with
// MAX_HOLD=4 share the same request stimulus and are checked against a model.
module tb_rr_hold_arbiter;

    localparam int N      = 5;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt0, gnt4;
    logic             gv0, gv4;
    logic [IDX_W-1:0] gi0, gi4;
    logic             st0, st4;

    int total = 0;
    int bad   = 0;

    // Model state: owner (-1 = none), next priority pointer, cycles held so far.
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];
    int maxh[2] = '{0, 4};

    int seq[$];
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(0), .HOLD_W(HOLD_W)) u_arb0 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_idx(gi0), .state_dbg(st0)
    );

    rr_hold_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(4), .HOLD_W(HOLD_W)) u_arb4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt4), .gnt_valid(gv4), .gnt_idx(gi4), .state_dbg(st4)
    );

    function automatic int pick_m(int m, logic [N-1:0] r, int excl);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr[m] + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = 0;
            m_held[m]  = 0;
        end
    endtask

    task automatic model_grant(int m, int w);
        m_owner[m] = w;
        m_ptr[m]   = (w + 1) % N;
        m_held[m]  = 1;
    endtask

    task automatic model_edge(logic [N-1:0] r);
        int w;
        for (int m = 0; m < 2; m++) begin
            if (m_owner[m] < 0) begin
                w = pick_m(m, r, -1);
                if (w >= 0) model_grant(m, w);
            end else if (!r[m_owner[m]]) begin
                w = pick_m(m, r, m_owner[m]);
                if (w >= 0) model_grant(m, w);
                else begin
                    m_owner[m] = -1;
                    m_held[m]  = 0;
                end
            end else if (maxh[m] != 0 && m_held[m] >= maxh[m] &&
                         pick_m(m, r, m_owner[m]) >= 0) begin
                model_grant(m, pick_m(m, r, m_owner[m]));
            end else begin
                m_held[m]++;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] eg0, eg4;
        eg0 = (m_owner[0] >= 0) ? (N'(1) << m_owner[0]) : '0;
        eg4 = (m_owner[1] >= 0) ? (N'(1) << m_owner[1]) : '0;
        check({tag, "_gnt0"}, 32'(gnt0), 32'(eg0));
        check({tag, "_gv0"},  32'(gv0),  32'(m_owner[0] >= 0));
        check({tag, "_idx0"}, 32'(gi0),  (m_owner[0] >= 0) ? 32'(m_owner[0]) : 32'd0);
        check({tag, "_st0"},  32'(st0),  32'(m_owner[0] >= 0));
        check({tag, "_oh0"},  32'($onehot0(gnt0)), 32'd1);
        check({tag, "_gnt4"}, 32'(gnt4), 32'(eg4));
        check({tag, "_gv4"},  32'(gv4),  32'(m_owner[1] >= 0));
        check({tag, "_idx4"}, 32'(gi4),  (m_owner[1] >= 0) ? 32'(m_owner[1]) : 32'd0);
        check({tag, "_st4"},  32'(st4),  32'(m_owner[1] >= 0));
        check({tag, "_oh4"},  32'($onehot0(gnt4)), 32'd1);
    endtask

    // Drive one request vector, let one rising edge pass, then compare.
    task automatic step(logic [N-1:0] r, string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        int steps;

        // Idle after reset.
        do_reset();
        for (int i = 0; i < 5; i++) step('0, "idle");

        // Single requester holds, then releases.
        for (int i = 0; i < 5; i++) begin
            step(5'b00100, "single");
            check("single_idx_const", 32'(gi0), 32'd2);
        end
        step('0, "single_drop");
        check("single_drop_const", 32'(gnt0), 32'd0);

        // Rotation with release handoff; MAX_HOLD=0 instance drives the pattern.
        do_reset();
        seq.delete();
        steps = 0;
        while (seq.size() < 6 && steps < 40) begin
            r = '1;
            if (m_owner[0] >= 0 && m_held[0] == 2) r[m_owner[0]] = 1'b0;
            step(r, "rr");
            check("rr_no_bubble", 32'(gv0), 32'd1);
            if (gv0 && (seq.size() == 0 || seq[$] != int'(gi0))) seq.push_back(int'(gi0));
            steps++;
        end
        check("rr_len", 32'(seq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < seq.size()) check("rr_order", 32'(seq[i]), 32'(exp_order[i]));

        // Hold limit: two contenders alternate every 4 cycles on the limited instance.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(5'b00011, "preempt");
            check("preempt_idx_const", 32'(gi4), 32'((k / 4) % 2));
            check("nolimit_idx_const", 32'(gi0), 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            step(5'b00001, "solo");
            check("solo_gnt4_const", 32'(gnt4), 32'd1);
        end

        // Pointer after owner 2 is 3, so 0 wins next; then pointer is 1.
        do_reset();
        step(5'b00100, "ptr_a");
        step('0, "ptr_b");
        step(5'b00011, "ptr_c");
        check("ptr3_win_const", 32'(gi0), 32'd0);
        step('0, "ptr_d");
        step(5'b00011, "ptr_e");
        check("ptr1_win_const", 32'(gi0), 32'd1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(5'b01000, "mid_a");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        check("mid_rst_gnt_const", 32'(gnt0), 32'd0);
        req = 5'b11000;
        rst = 1'b0;
        step(5'b11000, "mid_b");
        check("mid_rst_win_const", 32'(gi0), 32'd3);

        // Random request traffic with sticky bits.
        do_reset();
        r = '0;
        for (int s = 0; s < 600; s++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            step(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
